// File: rtl/router_fifo_if.sv
// -----------------------------------------------------------------------------
// router_fifo_if
// Write/read handshake bundle between the synchronizer, one router_fifo
// instance and that port's consumer.
//   write_enb  : this port's bit of the synchronizer's one-hot write enable
//   lfd_state  : data_in carries a header byte (same cycle as write_enb)
//   data_in    : byte to store
//   read_enb   : read request from the port's consumer
//   data_out   : registered read data
//   full/empty : occupancy status, decoded from the registered pointers
//   pkt_busy   : a packet has started draining and has not finished
// Modports: master = synchronizer/consumer side, slave = the FIFO itself.
// -----------------------------------------------------------------------------
interface router_fifo_if #(
  parameter int WIDTH = 8
);
  logic             write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             pkt_busy;

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, full, empty, pkt_busy
  );

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, full, empty, pkt_busy
  );
endinterface

// File: rtl/router_fifo.sv
// -----------------------------------------------------------------------------
// router_fifo
// Per-port output buffer of the 1x3 router. Stores packet bytes tagged with a
// header flag, reports full/empty to the synchronizer and tracks how many
// bytes of the current packet remain to be read (pkt_busy).
// Ports:
//   clk        : single clock, all state updates on the rising edge
//   resetn     : synchronous reset, ACTIVE-HIGH despite its legacy name
//   soft_reset : synchronous per-port flush from the synchronizer
//   bus        : router_fifo_if.slave (write/read handshake and status)
// Parameters: DEPTH (power of two, >= 4), WIDTH (>= 8; header length in [7:2]).
// -----------------------------------------------------------------------------
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          soft_reset,
  router_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Each entry is {header_flag, byte}.
  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [6:0]       pkt_cnt;
  logic [WIDTH-1:0] data_out_q;

  logic             full_w;
  logic             empty_w;
  logic             wr_ok;
  logic             rd_ok;
  logic             flush;
  logic [WIDTH:0]   rd_entry;

  // The extra MSB on each pointer distinguishes "same slot, same lap" (empty)
  // from "same slot, one lap apart" (full), so the decode survives any number
  // of wraps.
  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign flush   = resetn || soft_reset;
  // A write while full is dropped even when a read frees a slot this cycle.
  assign wr_ok   = bus.write_enb && !full_w;
  assign rd_ok   = bus.read_enb && !empty_w;

  assign rd_entry = mem[rd_ptr[AW-1:0]];

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.pkt_busy = (pkt_cnt != 7'd0);
  assign bus.data_out = data_out_q;

  // NOTE: storage is deliberately left out of reset; the pointers define what
  // is valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok && !flush) begin
      mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pkt_cnt    <= '0;
      data_out_q <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end

      if (rd_ok) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        data_out_q <= rd_entry[WIDTH-1:0];
        if (rd_entry[WIDTH]) begin
          // Header: payload length plus the trailing parity byte. Reloads
          // unconditionally so a truncated previous packet cannot stick.
          pkt_cnt <= {1'b0, rd_entry[7:2]} + 7'd1;
        end else if (pkt_cnt != 7'd0) begin
          pkt_cnt <= pkt_cnt - 7'd1;
        end
      end else if (pkt_cnt == 7'd0) begin
        // Idle between packets: present a clean zero on the output.
        data_out_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// -----------------------------------------------------------------------------
// tb_router_fifo
// Self-checking bench for router_fifo. A queue-based reference model tracks
// stored entries, the remaining-packet count and the expected data_out.
// -----------------------------------------------------------------------------
module tb_router_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic clk;
  logic resetn;
  logic soft_reset;

  router_fifo_if #(.WIDTH(WIDTH)) bus ();

  router_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [WIDTH:0]   q [$];
  int               m_cnt;
  logic [WIDTH-1:0] m_dout;

  logic [WIDTH+2:0] dut_vec;
  assign dut_vec = {bus.data_out, bus.full, bus.empty, bus.pkt_busy};

  function automatic logic [WIDTH+2:0] exp_vec();
    return {m_dout, q.size() == DEPTH, q.size() == 0, m_cnt != 0};
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, and return 1 time unit later so callers can sample outputs.
  task automatic step(input bit rst, input bit srst, input bit we, input bit lfd,
                      input logic [WIDTH-1:0] din, input bit re);
    logic [WIDTH:0] e;
    bit can_rd;
    bit can_wr;
    @(negedge clk);
    resetn        = rst;
    soft_reset    = srst;
    bus.write_enb = we;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    bus.read_enb  = re;
    @(posedge clk);
    if (rst || srst) begin
      q.delete();
      m_cnt  = 0;
      m_dout = '0;
    end else begin
      can_rd = re && (q.size() != 0);
      can_wr = we && (q.size() != DEPTH);
      if (can_rd) begin
        e      = q.pop_front();
        m_dout = e[WIDTH-1:0];
        if (e[WIDTH])       m_cnt = int'(e[7:2]) + 1;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else if (m_cnt == 0) begin
        m_dout = '0;
      end
      if (can_wr) q.push_back({lfd, din});
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, '0, 0);
    n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", bus.data_out); end
    n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    n_tests++; if (bus.pkt_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.pkt_busy); end
  endtask

  task automatic test_packet();
    step(0, 0, 1, 1, 8'h0D, 0);
    n_tests++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL pkt_empty_drop: got %b want 0", bus.empty); end
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'($urandom), 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, '0, 1);
      n_tests++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL pkt_read[%0d]: got %h want %h", i, dut_vec, exp_vec()); end
      if (i == 0) begin
        n_tests++; if ({bus.data_out, bus.pkt_busy} !== {8'h0D, 1'b1}) begin n_fail++; $display("FAIL pkt_header: got %h/%b want 0d/1", bus.data_out, bus.pkt_busy); end
      end
    end
    n_tests++; if (bus.pkt_busy !== 1'b0) begin n_fail++; $display("FAIL pkt_busy_end: got %b want 0", bus.pkt_busy); end
    step(0, 0, 0, 0, '0, 0);
    n_tests++; if ({bus.data_out, bus.empty} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL pkt_idle: got %h/%b want 00/1", bus.data_out, bus.empty); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 8'($urandom), 0);
    n_tests++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_set: got %b want 1", bus.full); end
    step(0, 0, 1, 0, 8'hEE, 0);
    n_tests++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_drop: got %b want 1", bus.full); end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 0, 0, '0, 1);
      n_tests++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL full_drain[%0d]: got %h want %h", i, dut_vec, exp_vec()); end
    end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL full_drained_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 8'($urandom), 0);
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, 0, 8'($urandom), 1);
      n_tests++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL b2b[%0d]: got %h want %h", i, dut_vec, exp_vec()); end
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, '0, 1);
      n_tests++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_soft_reset();
    step(0, 0, 1, 1, 8'h1C, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'($urandom), 0);
    step(0, 0, 0, 0, '0, 1);
    n_tests++; if (bus.pkt_busy !== 1'b1) begin n_fail++; $display("FAIL srst_pre_busy: got %b want 1", bus.pkt_busy); end
    step(0, 1, 1, 0, 8'hAA, 0);
    n_tests++; if ({bus.data_out, bus.empty, bus.pkt_busy} !== {8'h00, 1'b1, 1'b0}) begin n_fail++; $display("FAIL srst_state: got %h/%b/%b want 00/1/0", bus.data_out, bus.empty, bus.pkt_busy); end
    step(0, 0, 0, 0, '0, 1);
    n_tests++; if ({bus.data_out, bus.empty} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL srst_write_absent: got %h/%b want 00/1", bus.data_out, bus.empty); end
  endtask

  task automatic test_read_empty();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, '0, 1);
      n_tests++; if ({bus.data_out, bus.empty} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL rd_empty[%0d]: got %h/%b want 00/1", i, bus.data_out, bus.empty); end
    end
    step(0, 0, 1, 0, 8'h5A, 0);
    step(0, 0, 0, 0, '0, 1);
    n_tests++; if (bus.data_out !== 8'h5A) begin n_fail++; $display("FAIL rd_empty_ptr: got %h want 5a", bus.data_out); end
    n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rd_empty_after: got %b want 1", bus.empty); end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 1, 1, 8'h09, 0);  // length 2 -> count 3 after header read
    step(0, 0, 1, 0, 8'h11, 0);
    step(0, 0, 1, 0, 8'h22, 0);
    step(0, 0, 0, 0, '0, 1);
    n_tests++; if ({bus.data_out, bus.pkt_busy, bus.empty} !== {8'h09, 1'b1, 1'b0}) begin n_fail++; $display("FAIL mid_pre: got %h/%b/%b want 09/1/0", bus.data_out, bus.pkt_busy, bus.empty); end
    step(1, 0, 1, 0, 8'h33, 1);
    n_tests++; if (dut_vec !== {8'h00, 1'b0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL mid_reset: got %h want %h", dut_vec, {8'h00, 1'b0, 1'b1, 1'b0}); end
    step(0, 0, 1, 1, 8'h05, 0);
    n_tests++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL mid_fresh_wr: got %b want 0", bus.empty); end
    step(0, 0, 0, 0, '0, 1);
    n_tests++; if ({bus.data_out, bus.pkt_busy} !== {8'h05, 1'b1}) begin n_fail++; $display("FAIL mid_fresh_rd: got %h/%b want 05/1", bus.data_out, bus.pkt_busy); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(0, ($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 2) != 0);
      n_tests++; if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL rand[%0d]: got %h want %h", i, dut_vec, exp_vec()); end
    end
  endtask

  initial begin
    resetn        = 1'b1;
    soft_reset    = 1'b0;
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = '0;
    bus.read_enb  = 1'b0;
    m_cnt         = 0;
    m_dout        = '0;

    test_reset();
    test_packet();
    test_full();
    test_back_to_back();
    test_soft_reset();
    test_reset();
    test_read_empty();
    test_reset();
    test_reset_mid();
    test_reset();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-port output buffer of the 1x3 router, one instance per destination port, directly downstream of the synchronizer. It stores the bytes of a packet under the one-hot write enable selected by the synchronizer. It reports full/empty status back to the synchronizer, and the synchronizer turns empty into the port's valid-out. It also tracks packet boundaries so the read side can tell when a packet has finished draining, and it obeys the synchronizer's per-port soft reset.

## Interface
- DEPTH, 16, number of storage entries; power of two, at least 4.
- WIDTH, 8, data byte width; header byte layout is [7:2] payload length, [1:0] destination address.
- clk  in  1  single clock; all state updates on its rising edge.
- resetn  in  1  reset, synchronous and active-high: resetn=1 at a rising clk edge resets the block.
- soft_reset  in  1  per-port timeout flush from the synchronizer; synchronous, active-high.
- write_enb  in  1  this port's bit of the synchronizer's write_enb bus.
- lfd_state  in  1  high in the same cycle as write_enb when data_in is the header byte.
- data_in  in  WIDTH  byte to store.
- read_enb  in  1  read request from the port's consumer.
- data_out  out  WIDTH  registered read data.
- full  out  1  all DEPTH entries occupied.
- empty  out  1  no entries occupied; the synchronizer inverts it to form vld_out.
- pkt_busy  out  1  a packet has been started on the read side and has not fully drained.

## Operation
- Storage: DEPTH entries, each WIDTH+1 bits: {header_flag, byte}. On a write, header_flag is the value of lfd_state.
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH)+1 bits. The MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
- Write: accepted iff write_enb=1 and full=0.
  - The entry is stored at wr_ptr[low], then wr_ptr increments.
  - A write while full is dropped silently, even if a read happens in the same cycle.
- Read: accepted iff read_enb=1 and empty=0.
  - data_out takes the byte at rd_ptr[low], then rd_ptr increments.
  - read_enb while empty has no effect on the pointers.
- Packet counter pkt_cnt is 7 bits wide.
  - On an accepted read of an entry with header_flag=1, pkt_cnt loads byte[7:2]+1, covering the payload plus the parity byte. This reload happens even if pkt_cnt was not 0.
  - On an accepted read of an entry with header_flag=0 and pkt_cnt!=0, pkt_cnt decrements.
  - pkt_cnt never goes below 0.
  - pkt_busy = (pkt_cnt != 0).
- data_out rules:
  - Updated on an accepted read.
  - Cleared to 0 in any cycle with no accepted read and pkt_cnt==0.
  - Otherwise holds its value.
- Priority, highest first:
  - resetn: clears wr_ptr, rd_ptr, pkt_cnt and data_out; memory contents are don't-care.
  - soft_reset: clears exactly the same state as resetn; write and read in that cycle are ignored.
  - Normal operation.
- Simultaneous read and write when neither full nor empty: both are accepted and occupancy is unchanged.
- Simultaneous read and write when empty: only the write is accepted, and empty deasserts next cycle.

## Timing
- Values after reset or soft_reset: data_out=0, full=0, empty=1, pkt_busy=0.
- full and empty are decoded combinationally from the registered pointers. They therefore change in the cycle after the edge that accepted the write or read.
- Read latency is 1 cycle: read_enb sampled at edge N puts the byte on data_out after edge N.
- pkt_busy changes after the same edge as the corresponding data_out update.
- Wrap-around: pointers wrap modulo 2*DEPTH. The full/empty decode must remain correct across any number of wraps.
- Write throughput is one byte per cycle. Read throughput is one byte per cycle.

## Test plan
- Reset, then write a header 0x0D with lfd_state=1, then 3 payload bytes and 1 parity byte: empty drops one cycle after the first write. Reading five times gives data_out = 0x0D, then the payload bytes, then the parity byte. pkt_busy is 1 from the header read until the parity read; after that data_out=0 and empty=1.
- Write 16 bytes with no reads: full=1 after the 16th write. A 17th write is dropped. Draining returns exactly the first 16 bytes in order.
- Hold the FIFO at 8 entries and assert read_enb and write_enb together for 40 cycles: occupancy stays 8 and the data order is preserved across pointer wrap.
- Fill 5 bytes, then pulse soft_reset for one cycle while write_enb=1: next cycle empty=1, data_out=0 and pkt_busy=0; the write in the pulse cycle is absent.
- Assert read_enb while empty: the pointers do not move, data_out stays 0 and empty stays 1.
- Assert resetn mid-packet, with pkt_cnt=3 and 2 entries held: after the edge, all outputs are at their reset values, and a fresh header is accepted on the next cycle.
